// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and its rx_mod companion:
// oversampling ratio, FSM state encoding and a small constant helper.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tx_mod.sv
// UART transmitter: start bit, NB_DATA data bits LSB first, stop bit of
// STOP_TICKS baud ticks; 16 baud ticks per bit, line driven from a flop.
module tx_mod
  import uart_pkg::*;
#(
  parameter int NB_DATA    = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_s_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_tx_data,
  output logic               o_tx,
  output logic               o_tx_busy,
  output logic               o_tx_done_tick
);

  localparam int SW = $clog2(max_int(OVERSAMPLE, STOP_TICKS));
  localparam int NW = max_int(1, $clog2(NB_DATA));

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(STOP_TICKS - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(NB_DATA - 1);

  uart_state_e        state, state_n;
  logic [SW-1:0]      s, s_n;
  logic [NW-1:0]      n, n_n;
  logic [NB_DATA-1:0] b, b_n;
  logic               tx_q, tx_n;
  logic               done;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
      tx_q  <= 1'b1;
    end else begin
      state <= state_n;
      s     <= s_n;
      n     <= n_n;
      b     <= b_n;
      tx_q  <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (i_tx_start) begin
          b_n     = i_tx_data;
          s_n     = '0;
          state_n = START;
        end
      end
      START: begin
        if (i_s_tick) begin
          if (s == S_BIT_LAST) begin
            s_n     = '0;
            n_n     = '0;
            state_n = DATA;
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      DATA: begin
        if (i_s_tick) begin
          if (s == S_BIT_LAST) begin
            s_n = '0;
            b_n = b >> 1;
            if (n == N_LAST) state_n = STOP;
            else             n_n     = n + NW'(1);
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      STOP: begin
        if (i_s_tick) begin
          if (s == S_STOP_LAST) begin
            state_n = IDLE;
            done    = 1'b1;
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level follows the state being entered, so o_tx comes straight off a flop.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = b_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  assign o_tx           = tx_q;
  assign o_tx_busy      = (state != IDLE);
  assign o_tx_done_tick = done;

endmodule

// File: tb/tb_tx_mod.sv
// Bench for tx_mod: two instances (1 and 2 stop bits) on a shared 1-in-3 baud
// tick; a tick-sampling line monitor checks each frame against a queued word.
module tb_tx_mod;

  typedef struct {
    logic [7:0] data;
    bit         contig;
  } item_t;

  logic clk, rst_n, tick;
  logic start0, start1;
  logic [7:0] data0, data1;
  logic tx0, tx1, busy0, busy1, done0, done1;
  logic [1:0] tx, busy, done;

  assign tx   = {tx1, tx0};
  assign busy = {busy1, busy0};
  assign done = {done1, done0};

  int checks   = 0;
  int failures = 0;

  item_t q0[$];
  item_t q1[$];

  tx_mod #(.NB_DATA(8), .STOP_TICKS(16)) u_dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_s_tick(tick),
    .i_tx_start(start0), .i_tx_data(data0),
    .o_tx(tx0), .o_tx_busy(busy0), .o_tx_done_tick(done0)
  );

  tx_mod #(.NB_DATA(8), .STOP_TICKS(32)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_s_tick(tick),
    .i_tx_start(start1), .i_tx_data(data1),
    .o_tx(tx1), .o_tx_busy(busy1), .o_tx_done_tick(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    int tc;
    tc   = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick = (tc % 3 == 0);
      tc++;
    end
  end

  // Expected line level at tick-sample k of a frame carrying word w.
  function automatic logic exp_bit(input logic [7:0] w, input int k);
    if (k < 16)  return 1'b0;
    if (k < 144) return w[(k - 16) / 16];
    return 1'b1;
  endfunction

  task automatic push_exp(input int d, input logic [7:0] w, input bit contig);
    item_t it;
    it.data   = w;
    it.contig = contig;
    if (d == 0) q0.push_back(it);
    else        q1.push_back(it);
  endtask

  task automatic pop_exp(input int d, output item_t it, output bit ok);
    ok = 1'b0;
    it.data = '0;
    it.contig = 1'b0;
    if (d == 0 && q0.size() > 0) begin it = q0.pop_front(); ok = 1'b1; end
    if (d == 1 && q1.size() > 0) begin it = q1.pop_front(); ok = 1'b1; end
  endtask

  // Monitor: one line sample per baud tick, compared with the ideal frame shape.
  bit         in_frame[2];
  int         idx[2];
  int         idle_cnt[2];
  int         nerr[2];
  logic [7:0] cur[2];
  logic [7:0] word[2];

  always @(negedge clk) begin
    int    flen;
    logic  v;
    item_t it;
    bit    ok;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        in_frame[d] = 1'b0;
        idle_cnt[d] = 1000;
      end
      q0.delete();
      q1.delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        flen = 16 + 16 * 8 + ((d == 0) ? 16 : 32);
        if (tick) begin
          v = tx[d];
          if (!in_frame[d]) begin
            if (v == 1'b0) begin
              pop_exp(d, it, ok);
              checks++;
              if (!ok) begin
                failures++;
                $display("FAIL unexpected_frame dut%0d: start bit seen, none expected", d);
              end else begin
                in_frame[d] = 1'b1;
                idx[d]      = 0;
                nerr[d]     = 0;
                cur[d]      = it.data;
                word[d]     = '0;
                if (it.contig) begin
                  checks++;
                  if (idle_cnt[d] != 0) begin
                    failures++;
                    $display("FAIL frame_gap dut%0d: idle ticks=%0d required=0", d, idle_cnt[d]);
                  end
                end
              end
            end else begin
              idle_cnt[d]++;
            end
          end
          if (in_frame[d]) begin
            if (v !== exp_bit(cur[d], idx[d])) nerr[d]++;
            if (idx[d] >= 16 && idx[d] < 144 && ((idx[d] - 16) % 16) == 7)
              word[d][(idx[d] - 16) / 16] = v;
            if (idx[d] == flen - 1) begin
              checks += 3;
              if (done[d] !== 1'b1) begin
                failures++;
                $display("FAIL done_at_stop_end dut%0d: done=%b required=1", d, done[d]);
              end
              if (nerr[d] != 0) begin
                failures++;
                $display("FAIL frame_shape dut%0d word=%h: bad tick samples=%0d required=0",
                         d, cur[d], nerr[d]);
              end
              if (word[d] !== cur[d]) begin
                failures++;
                $display("FAIL rx_word dut%0d: got=%h required=%h", d, word[d], cur[d]);
              end
              in_frame[d] = 1'b0;
              idle_cnt[d] = 0;
            end else if (done[d]) begin
              checks++;
              failures++;
              $display("FAIL early_done dut%0d: done at sample %0d required at %0d",
                       d, idx[d], flen - 1);
            end
            idx[d]++;
          end else if (done[d]) begin
            checks++;
            failures++;
            $display("FAIL spurious_done dut%0d: done=1 while line idle, required 0", d);
          end
        end else if (done[d]) begin
          checks++;
          failures++;
          $display("FAIL done_off_tick dut%0d: done=1 without tick, required 0", d);
        end
      end
    end
  end

  task automatic set_req(input int d, input bit on, input logic [7:0] w);
    if (d == 0) begin start0 = on; data0 = w; end
    else        begin start1 = on; data1 = w; end
  endtask

  task automatic send(input int d, input logic [7:0] w, input bit contig);
    int t;
    t = 0;
    @(posedge clk); #1;
    while (busy[d] && t < 2000) begin @(posedge clk); #1; t++; end
    checks++;
    if (busy[d]) begin
      failures++;
      $display("FAIL send_wait dut%0d: busy=%b required=0", d, busy[d]);
    end
    push_exp(d, w, contig);
    set_req(d, 1'b1, w);
    @(posedge clk); #1;
    set_req(d, 1'b0, 8'($urandom));
  endtask

  task automatic wait_done(input int d);
    int t;
    t = 0;
    @(negedge clk);
    while (!done[d] && t < 3000) begin @(negedge clk); t++; end
    checks++;
    if (!done[d]) begin
      failures++;
      $display("FAIL done_timeout dut%0d: done=%b required=1", d, done[d]);
    end
  endtask

  initial begin
    #600000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, t;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    data0  = 8'h00;
    data1  = 8'h00;

    // Reset state, held across ticks and a pending request.
    start0 = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (tx !== 2'b11 || busy !== 2'b00 || done !== 2'b00) begin
        failures++;
        $display("FAIL reset_state: tx=%b busy=%b done=%b required tx=11 busy=00 done=00",
                 tx, busy, done);
      end
    end
    start0 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // Directed 0xA5, then back-to-back 0x00 / 0xFF.
    send(0, 8'hA5, 1'b0);
    wait_done(0);
    send(0, 8'h00, 1'b0);
    wait_done(0);
    send(0, 8'hFF, 1'b1);
    wait_done(0);

    // Request during DATA of 0x81 must be dropped.
    send(0, 8'h81, 1'b0);
    repeat ((16 + 16 * 3 + 8) * 3) @(posedge clk);
    #1;
    set_req(0, 1'b1, 8'h3C);
    repeat (5) @(posedge clk);
    #1;
    set_req(0, 1'b0, 8'h3C);
    wait_done(0);
    repeat (80) @(posedge clk);

    // Start held high: three frames back to back.
    push_exp(0, 8'h5A, 1'b0);
    push_exp(0, 8'h5A, 1'b1);
    push_exp(0, 8'h5A, 1'b1);
    @(posedge clk); #1;
    set_req(0, 1'b1, 8'h5A);
    ndone = 0;
    t     = 0;
    while (ndone < 3 && t < 5000) begin
      @(negedge clk);
      if (done[0]) ndone++;
      t++;
    end
    set_req(0, 1'b0, 8'h00);
    checks++;
    if (ndone != 3) begin
      failures++;
      $display("FAIL held_start_frames: done pulses=%0d required=3", ndone);
    end
    repeat (60) @(posedge clk);

    // Asynchronous reset in a zero data bit (bit 5) of 0x55.
    send(0, 8'h55, 1'b0);
    repeat ((16 + 16 * 5 + 8) * 3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tx[0] !== 1'b0 || busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL pre_abort: tx=%b busy=%b required tx=0 busy=1", tx[0], busy[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      failures++;
      $display("FAIL async_abort: tx=%b busy=%b done=%b required tx=1 busy=0 done=0",
               tx[0], busy[0], done[0]);
    end
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    send(0, 8'h12, 1'b0);
    wait_done(0);

    // Two stop bits: 176-tick frame.
    send(1, 8'hC3, 1'b0);
    wait_done(1);

    // Random words on both instances with random idle gaps.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 20)) @(posedge clk);
      send(0, 8'($urandom), 1'b0);
      wait_done(0);
    end
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 20)) @(posedge clk);
      send(1, 8'($urandom), 1'b0);
      wait_done(1);
    end

    repeat (40) @(posedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0 || in_frame[0] || in_frame[1]) begin
      failures++;
      $display("FAIL drain: pending=%0d/%0d in_frame=%b/%b required 0/0 0/0",
               q0.size(), q1.size(), in_frame[0], in_frame[1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
